id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 id_valid/id_ready  in/out  1/1  decode-side handshake; transfer when both high on a clock edge.
REQ-004 id_pc, id_rs1_data, id_rs2_data, id_imm  in  32 each  decoded operands and immediate.
REQ-005 id_rs1, id_rs2, id_rd  in  5 each  register indices.
REQ-006 id_alu_ctl  in  5  ALU op code (package encoding); id_src_a_pc, id_src_b_imm, id_reg_we, id_mem_rd  in  1 each.
REQ-007 flush  in  1  kill the instruction being captured and the one held.
REQ-008 ex_ready  in  1  downstream (EX/MEM) accepts the held instruction.
REQ-009 mem_rd 5, mem_reg_we 1, mem_result 32  in  EX/MEM forwarding source; wb_rd 5, wb_reg_we 1, wb_result 32  in  MEM/WB forwarding source.
REQ-010 ex_valid  out 1; alu_a, alu_b  out 32; alu_ctl  out 5; ex_store_data  out 32; ex_pc  out 32; ex_rd  out 5; ex_reg_we, ex_mem_rd  out 1.

Function
REQ-011 One-entry pipeline register; captured instruction appears on outputs one cycle after the id_valid&&id_ready edge.
REQ-012 Register loads when !ex_valid || ex_ready; otherwise holds.
REQ-013 id_ready = (!ex_valid || ex_ready) && !hazard, where hazard is defined in REQ-016/REQ-024.
REQ-014 alu_a = ex_src_a_pc ? ex_pc : fwd(rs1); alu_b = ex_src_b_imm ? ex_imm : fwd(rs2); ex_store_data = fwd(rs2).
REQ-015 fwd(rsX): EX/MEM match (mem_reg_we, mem_rd==rsX, rsX!=0) wins over MEM/WB match, else registered data; index 0 never forwarded.
REQ-016 Load-use: ex_valid && ex_mem_rd && ex_rd!=0 && id_valid && (ex_rd==id_rs1 || ex_rd==id_rs2) -> id_ready=0; if ex_ready, register loads a bubble (ex_valid=0).
REQ-017 While holding (ex_valid && !ex_ready), a MEM/WB match rewrites the held rs1/rs2 data with wb_result so retiring values are not lost.
REQ-018 flush has priority over stall and capture: next edge ex_valid=0; id_ready=1 during flush; captured data discarded.
REQ-019 Bubble/flushed entries force ex_reg_we=0 and ex_mem_rd=0.
REQ-020 Simultaneous load-use and ex_ready=0: hold, no bubble, id_ready=0.

Reset
REQ-021 On rst: ex_valid=0, ex_reg_we=0, ex_mem_rd=0, all data/index fields 0, alu_ctl=ADD (5'b00001) so the ALU output is defined.
REQ-022 Reset asserted mid-transfer discards the in-flight instruction; first capture is on the first edge after rst deasserts.

Configuration
REQ-023 FORWARD_EN defined: REQ-015 and REQ-017 forwarding muxes present.
REQ-024 FORWARD_EN undefined: fwd(rsX) = registered data; hazard also asserted when id_rs1/id_rs2 (nonzero) match a valid ex_rd with ex_reg_we or mem_rd with mem_reg_we; register file is write-first so wb is excluded.

Structure
REQ-025 Shared package cpu_pkg holds the 5-bit ALU op encodings (ADD 00001 ... ADDU 10010), XLEN=32 and register-index width 5.
REQ-026 One sub-module fwd_mux (per-operand 3-way forwarding select), instantiated twice.

Verification
REQ-027 Reset: assert rst mid-capture -> ex_valid=0, alu_ctl=5'b00001, alu_a=alu_b=0 immediately.
REQ-028 EX/MEM forward: held rs1=5, rs1_data=1, mem_rd=5, mem_reg_we=1, mem_result=0x1234 -> alu_a=0x1234; with wb_rd=5 also set, still 0x1234.
REQ-029 Load-use: held lw with ex_rd=7; id_rs2=7 -> id_ready=0 one cycle, bubble (ex_valid=0), add issued next cycle.
REQ-030 Stall plus WB capture: ex_ready=0 for 3 cycles, wb_rd=rs1 with wb_result=0xABCD in cycle 2 -> after release alu_a=0xABCD.
REQ-031 flush with id_valid=1 and ex_ready=0 -> next cycle ex_valid=0, ex_reg_we=0.
REQ-032 FORWARD_EN undefined: id_rs1 equals mem_rd with mem_reg_we=1 -> id_ready=0 until match clears; rs1=0 never stalls.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths, ALU op encodings and the ID/EX pipeline entry type
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int REG_W = 5;
  typedef enum logic [4:0] {
    ALU_ADD   = 5'b00001,
    ALU_SUB   = 5'b00010,
    ALU_SLL   = 5'b00011,
    ALU_SLT   = 5'b00100,
    ALU_SLTU  = 5'b00101,
    ALU_XOR   = 5'b00110,
    ALU_SRL   = 5'b00111,
    ALU_SRA   = 5'b01000,
    ALU_OR    = 5'b01001,
    ALU_AND   = 5'b01010,
    ALU_MUL   = 5'b01011,
    ALU_MULH  = 5'b01100,
    ALU_MULHU = 5'b01101,
    ALU_DIV   = 5'b01110,
    ALU_DIVU  = 5'b01111,
    ALU_REM   = 5'b10000,
    ALU_REMU  = 5'b10001,
    ALU_ADDU  = 5'b10010
  } alu_op_e;
  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [4:0]       alu_ctl;
    logic             src_a_pc;
    logic             src_b_imm;
    logic             reg_we;
    logic             mem_rd;
  } id_ex_t;
  localparam id_ex_t ID_EX_RST = '{alu_ctl: ALU_ADD, default: '0};
  function automatic logic idx_hit(input logic we, input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs);
    return we && rd == rs && rs != '0;
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side handshake, forwarding sources and EX-side outputs of the ID/EX register
interface id_ex_stage_if;
  import cpu_pkg::*;
  logic              id_valid;
  logic              id_ready;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [REG_W-1:0]  id_rs1;
  logic [REG_W-1:0]  id_rs2;
  logic [REG_W-1:0]  id_rd;
  logic [4:0]        id_alu_ctl;
  logic              id_src_a_pc;
  logic              id_src_b_imm;
  logic              id_reg_we;
  logic              id_mem_rd;
  logic              flush;
  logic              ex_ready;
  logic [REG_W-1:0]  mem_rd;
  logic              mem_reg_we;
  logic [XLEN-1:0]   mem_result;
  logic [REG_W-1:0]  wb_rd;
  logic              wb_reg_we;
  logic [XLEN-1:0]   wb_result;
  logic              ex_valid;
  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [4:0]        alu_ctl;
  logic [XLEN-1:0]   ex_store_data;
  logic [XLEN-1:0]   ex_pc;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_reg_we;
  logic              ex_mem_rd;
  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_ctl, id_src_a_pc, id_src_b_imm, id_reg_we, id_mem_rd, flush, ex_ready,
           mem_rd, mem_reg_we, mem_result, wb_rd, wb_reg_we, wb_result,
    input  id_ready, ex_valid, alu_a, alu_b, alu_ctl, ex_store_data, ex_pc, ex_rd, ex_reg_we, ex_mem_rd
  );
  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_ctl, id_src_a_pc, id_src_b_imm, id_reg_we, id_mem_rd, flush, ex_ready,
           mem_rd, mem_reg_we, mem_result, wb_rd, wb_reg_we, wb_result,
    output id_ready, ex_valid, alu_a, alu_b, alu_ctl, ex_store_data, ex_pc, ex_rd, ex_reg_we, ex_mem_rd
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: per-operand select of EX/MEM result, MEM/WB result or registered data (EX/MEM wins, x0 never forwarded)
module fwd_mux
  import cpu_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic [REG_W-1:0] i_rs,
  input  logic [XLEN-1:0]  i_data,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_we,
  input  logic [XLEN-1:0]  i_mem_result,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_wb_we,
  input  logic [XLEN-1:0]  i_wb_result,
  output logic [XLEN-1:0]  o_data
);
  logic w_mem_hit, w_wb_hit;
  assign w_mem_hit = EN && idx_hit(i_mem_we, i_mem_rd, i_rs);
  assign w_wb_hit  = EN && idx_hit(i_wb_we, i_wb_rd, i_rs);
  assign o_data = w_mem_hit ? i_mem_result : w_wb_hit ? i_wb_result : i_data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: one-entry ID/EX pipeline register with load-use stall, flush and operand forwarding (FORWARD_EN)
module id_ex_stage
  import cpu_pkg::*;
(
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);
`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic             r_valid;
  id_ex_t           r_ex;
  id_ex_t           w_id;
  logic             w_load, w_load_use, w_raw, w_hazard, w_capture;
  logic [XLEN-1:0]  w_rs1_fwd, w_rs2_fwd;
  assign w_id = '{pc: bus.id_pc, rs1_data: bus.id_rs1_data, rs2_data: bus.id_rs2_data, imm: bus.id_imm,
                  rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd, alu_ctl: bus.id_alu_ctl,
                  src_a_pc: bus.id_src_a_pc, src_b_imm: bus.id_src_b_imm,
                  reg_we: bus.id_reg_we, mem_rd: bus.id_mem_rd};
  assign w_load = !r_valid || bus.ex_ready;
  assign w_load_use = r_valid && r_ex.mem_rd && r_ex.rd != '0 && bus.id_valid &&
                      (r_ex.rd == bus.id_rs1 || r_ex.rd == bus.id_rs2);
  // without forwarding any pending write to a source register must drain first; WB is write-first in the regfile
  assign w_raw = !FWD && bus.id_valid &&
                 (idx_hit(r_valid && r_ex.reg_we, r_ex.rd, bus.id_rs1) ||
                  idx_hit(r_valid && r_ex.reg_we, r_ex.rd, bus.id_rs2) ||
                  idx_hit(bus.mem_reg_we, bus.mem_rd, bus.id_rs1) ||
                  idx_hit(bus.mem_reg_we, bus.mem_rd, bus.id_rs2));
  assign w_hazard = w_load_use || w_raw;
  assign w_capture = bus.id_valid && w_load && !w_hazard;
  assign bus.id_ready = bus.flush || (w_load && !w_hazard);
  // flush beats everything; a load slot with nothing to take becomes a bubble; a held entry soaks up retiring WB values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ex <= ID_EX_RST;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_ex.reg_we <= 1'b0;
      r_ex.mem_rd <= 1'b0;
    end else if (w_load) begin
      r_valid <= w_capture;
      if (w_capture) r_ex <= w_id;
      else begin
        r_ex.reg_we <= 1'b0;
        r_ex.mem_rd <= 1'b0;
      end
    end else if (FWD) begin
      if (idx_hit(bus.wb_reg_we, bus.wb_rd, r_ex.rs1)) r_ex.rs1_data <= bus.wb_result;
      if (idx_hit(bus.wb_reg_we, bus.wb_rd, r_ex.rs2)) r_ex.rs2_data <= bus.wb_result;
    end
  end
  fwd_mux #(.EN(FWD)) u_fwd_rs1 (
    .i_rs(r_ex.rs1), .i_data(r_ex.rs1_data),
    .i_mem_rd(bus.mem_rd), .i_mem_we(bus.mem_reg_we), .i_mem_result(bus.mem_result),
    .i_wb_rd(bus.wb_rd), .i_wb_we(bus.wb_reg_we), .i_wb_result(bus.wb_result),
    .o_data(w_rs1_fwd)
  );
  fwd_mux #(.EN(FWD)) u_fwd_rs2 (
    .i_rs(r_ex.rs2), .i_data(r_ex.rs2_data),
    .i_mem_rd(bus.mem_rd), .i_mem_we(bus.mem_reg_we), .i_mem_result(bus.mem_result),
    .i_wb_rd(bus.wb_rd), .i_wb_we(bus.wb_reg_we), .i_wb_result(bus.wb_result),
    .o_data(w_rs2_fwd)
  );
  assign bus.ex_valid      = r_valid;
  assign bus.alu_a         = r_ex.src_a_pc ? r_ex.pc : w_rs1_fwd;
  assign bus.alu_b         = r_ex.src_b_imm ? r_ex.imm : w_rs2_fwd;
  assign bus.alu_ctl       = r_ex.alu_ctl;
  assign bus.ex_store_data = w_rs2_fwd;
  assign bus.ex_pc         = r_ex.pc;
  assign bus.ex_rd         = r_ex.rd;
  assign bus.ex_reg_we     = r_ex.reg_we;
  assign bus.ex_mem_rd     = r_ex.mem_rd;
endmodule
